nts_timestamp_core: RTL and testbench

Builds the 48-byte NTP server response header for the NTS engine. Records the receive timestamp on parser request and, on a transmit request, streams six 64-bit header words to the TX buffer. Header words are assembled from parser fields, the live NTP clock and API-programmed server parameters. Sits between the packet parser, the NTP clock and the TX packet writer, with a 32-bit register API.

---
 rtl/nts_timestamp_core_if.sv | 35 +++
 rtl/nts_timestamp_core.sv | 176 +++++++++++++++++
 tb/tb_nts_timestamp_core.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_timestamp_core_if.sv
// ============================================================================
// Module      : nts_timestamp_core_if
// Description : Bus bundle for nts_timestamp_core. Carries the 32-bit
//               register API and the TX header-word write port.
//               master : host side (drives API, receives header words)
//               slave  : the timestamp core
// Ports       : i_api_cs, i_api_we, i_api_address[7:0], i_api_write_data[31:0],
//               o_api_read_data[31:0], o_tx_wr_en, o_tx_ntp_header_block[2:0],
//               o_tx_ntp_header_data[63:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nts_timestamp_core_if;
    logic        i_api_cs;
    logic        i_api_we;
    logic [7:0]  i_api_address;
    logic [31:0] i_api_write_data;
    logic [31:0] o_api_read_data;
    logic        o_tx_wr_en;
    logic [2:0]  o_tx_ntp_header_block;
    logic [63:0] o_tx_ntp_header_data;

    modport master (
        output i_api_cs, i_api_we, i_api_address, i_api_write_data,
        input  o_api_read_data, o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data
    );

    modport slave (
        input  i_api_cs, i_api_we, i_api_address, i_api_write_data,
        output o_api_read_data, o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data
    );
endinterface

`default_nettype wire

// File: rtl/nts_timestamp_core.sv
// ============================================================================
// Module      : nts_timestamp_core
// Description : Builds the 48-byte NTP server response header. Latches the
//               receive timestamp on parser request and, on transmit, streams
//               six 64-bit header words to the TX buffer.
// Ports       : i_clk, i_areset (async, active-low), i_ntp_time[63:0],
//               o_busy, i_parser_clear, i_parser_record_receive_timestamp,
//               i_parser_transmit, i_parser_origin_timestamp[63:0],
//               i_parser_version_number[2:0], i_parser_poll[7:0],
//               bus (API + TX write port, slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nts_timestamp_core (
    input  wire logic        i_clk,
    input  wire logic        i_areset,
    input  wire logic [63:0] i_ntp_time,
    output logic             o_busy,
    input  wire logic        i_parser_clear,
    input  wire logic        i_parser_record_receive_timestamp,
    input  wire logic        i_parser_transmit,
    input  wire logic [63:0] i_parser_origin_timestamp,
    input  wire logic [2:0]  i_parser_version_number,
    input  wire logic [7:0]  i_parser_poll,
    nts_timestamp_core_if.slave bus
);

    localparam logic [7:0]  C_ADDR_NAME0      = 8'h00;
    localparam logic [7:0]  C_ADDR_NAME1      = 8'h01;
    localparam logic [7:0]  C_ADDR_CONFIG     = 8'h10;
    localparam logic [7:0]  C_ADDR_ROOT_DELAY = 8'h11;
    localparam logic [7:0]  C_ADDR_ROOT_DISP  = 8'h12;
    localparam logic [7:0]  C_ADDR_REF_ID     = 8'h13;
    localparam logic [7:0]  C_ADDR_TX_OFS     = 8'h14;
    localparam logic [31:0] C_NAME0           = 32'h74696d65;
    localparam logic [31:0] C_NAME1           = 32'h73746d70;
    localparam logic [2:0]  C_LAST_BLOCK      = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_config;
    logic [31:0] r_root_delay;
    logic [31:0] r_root_disp;
    logic [31:0] r_ref_id;
    logic [31:0] r_tx_ofs;
    logic [31:0] r_api_read_data;
    logic [63:0] r_rx_ts;
    logic [63:0] r_tx_ts;
    logic [31:0] r_ref_sec;
    logic [63:0] r_origin;
    logic        r_busy;
    logic        r_wr_en;
    logic [2:0]  r_block;
    logic [63:0] r_data;

    logic [31:0] w_read_mux;
    logic [63:0] w_block0;
    logic [63:0] w_next_word;

    always_comb begin
        w_read_mux = 32'h0;
        case (bus.i_api_address)
            C_ADDR_NAME0:      w_read_mux = C_NAME0;
            C_ADDR_NAME1:      w_read_mux = C_NAME1;
            C_ADDR_CONFIG:     w_read_mux = r_config;
            C_ADDR_ROOT_DELAY: w_read_mux = r_root_delay;
            C_ADDR_ROOT_DISP:  w_read_mux = r_root_disp;
            C_ADDR_REF_ID:     w_read_mux = r_ref_id;
            C_ADDR_TX_OFS:     w_read_mux = r_tx_ofs;
            default:           w_read_mux = 32'h0;
        endcase
    end

    // Block 0 is formed on the accepting edge straight from the parser
    // fields, so version and poll never need a separate holding register.
    assign w_block0 = {r_config[31:30], i_parser_version_number, 3'd4, 8'h01,
                       i_parser_poll, r_config[7:0], r_root_delay};

    // Word that follows the one currently on the bus.
    always_comb begin
        w_next_word = 64'h0;
        case (r_block)
            3'd0:    w_next_word = {r_root_disp, r_ref_id};
            3'd1:    w_next_word = {r_ref_sec, 32'h0};
            3'd2:    w_next_word = r_origin;
            3'd3:    w_next_word = r_rx_ts;
            3'd4:    w_next_word = r_tx_ts;
            default: w_next_word = 64'h0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset) begin
        if (!i_areset) begin
            r_state         <= ST_IDLE;
            r_config        <= 32'h0;
            r_root_delay    <= 32'h0;
            r_root_disp     <= 32'h0;
            r_ref_id        <= 32'h0;
            r_tx_ofs        <= 32'h0;
            r_api_read_data <= 32'h0;
            r_rx_ts         <= 64'h0;
            r_tx_ts         <= 64'h0;
            r_ref_sec       <= 32'h0;
            r_origin        <= 64'h0;
            r_busy          <= 1'b0;
            r_wr_en         <= 1'b0;
            r_block         <= 3'd0;
            r_data          <= 64'h0;
        end else begin
            // Read data is a one-cycle response; zero otherwise.
            r_api_read_data <= 32'h0;
            if (bus.i_api_cs) begin
                if (bus.i_api_we) begin
                    case (bus.i_api_address)
                        C_ADDR_CONFIG:     r_config     <= bus.i_api_write_data;
                        C_ADDR_ROOT_DELAY: r_root_delay <= bus.i_api_write_data;
                        C_ADDR_ROOT_DISP:  r_root_disp  <= bus.i_api_write_data;
                        C_ADDR_REF_ID:     r_ref_id     <= bus.i_api_write_data;
                        C_ADDR_TX_OFS:     r_tx_ofs     <= bus.i_api_write_data;
                        default:           ;
                    endcase
                end else begin
                    r_api_read_data <= w_read_mux;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_parser_clear) begin
                        r_rx_ts <= 64'h0;
                    end else if (i_parser_record_receive_timestamp) begin
                        r_rx_ts <= i_ntp_time;
                    end
                    if (i_parser_transmit) begin
                        r_state   <= ST_SEND;
                        r_busy    <= 1'b1;
                        r_wr_en   <= 1'b1;
                        r_block   <= 3'd0;
                        r_data    <= w_block0;
                        r_origin  <= i_parser_origin_timestamp;
                        r_tx_ts   <= i_ntp_time + {32'h0, r_tx_ofs};
                        // Reference time: one second before now, no fraction.
                        r_ref_sec <= i_ntp_time[63:32] - 32'd1;
                    end
                end
                ST_SEND: begin
                    if (r_block == C_LAST_BLOCK) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_wr_en <= 1'b0;
                        r_block <= 3'd0;
                        r_data  <= 64'h0;
                    end else begin
                        r_block <= r_block + 3'd1;
                        r_data  <= w_next_word;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy                    = r_busy;
    assign bus.o_api_read_data       = r_api_read_data;
    assign bus.o_tx_wr_en            = r_wr_en;
    assign bus.o_tx_ntp_header_block = r_block;
    assign bus.o_tx_ntp_header_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_nts_timestamp_core.sv
// ============================================================================
// Module      : tb_nts_timestamp_core
// Description : Self-checking bench for nts_timestamp_core. Table-driven API
//               vectors followed by hand-written header transmit sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nts_timestamp_core;

    logic        clk;
    logic        areset;
    logic [63:0] ntp_time;
    logic        busy;
    logic        p_clear;
    logic        p_record;
    logic        p_transmit;
    logic [63:0] p_origin;
    logic [2:0]  p_version;
    logic [7:0]  p_poll;
    logic        inc_time;

    int total;
    int bad;

    // Bench copies of programmed register values.
    logic [31:0] m_config;
    logic [31:0] m_root_delay;
    logic [31:0] m_root_disp;
    logic [31:0] m_ref_id;
    logic [63:0] last_words [6];

    nts_timestamp_core_if bus ();

    nts_timestamp_core dut (
        .i_clk                             (clk),
        .i_areset                          (areset),
        .i_ntp_time                        (ntp_time),
        .o_busy                            (busy),
        .i_parser_clear                    (p_clear),
        .i_parser_record_receive_timestamp (p_record),
        .i_parser_transmit                 (p_transmit),
        .i_parser_origin_timestamp         (p_origin),
        .i_parser_version_number           (p_version),
        .i_parser_poll                     (p_poll),
        .bus                               (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; ntp_time advances after each edge so the bench always
    // knows the value the DUT sampled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inc_time) ntp_time = ntp_time + 64'd1;
    endtask

    task automatic api_write(input logic [7:0] a, input logic [31:0] d);
        bus.i_api_cs = 1'b1; bus.i_api_we = 1'b1;
        bus.i_api_address = a; bus.i_api_write_data = d;
        tick();
        bus.i_api_cs = 1'b0; bus.i_api_we = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"},  {63'h0, busy}, 64'h0);
        chk({tag, " wr_en"}, {63'h0, bus.o_tx_wr_en}, 64'h0);
        chk({tag, " block"}, {61'h0, bus.o_tx_ntp_header_block}, 64'h0);
        chk({tag, " data"},  bus.o_tx_ntp_header_data, 64'h0);
    endtask

    // mode 0: record twice then transmit
    // mode 1: as 0, plus transmit/record pulses while busy
    // mode 2: clear and record together, then transmit
    task automatic run_tx(input int mode, input logic [63:0] ofs,
                          input logic [2:0] ver, input logic [7:0] poll);
        logic [63:0] exp [6];
        logic [63:0] t_rec;
        logic [63:0] t_tx;
        if (mode == 2) begin
            p_clear = 1'b1; p_record = 1'b1;
            tick();
            p_clear = 1'b0; p_record = 1'b0;
            t_rec = 64'h0;
        end else begin
            p_record = 1'b1;
            tick();
            t_rec = ntp_time;
            tick();
            p_record = 1'b0;
        end
        p_origin   = ntp_time ^ 64'h5a5a_0000_1234_ffff;
        p_version  = ver;
        p_poll     = poll;
        p_transmit = 1'b1;
        t_tx       = ntp_time;
        exp[0] = {m_config[31:30], ver, 3'd4, 8'h01, poll, m_config[7:0], m_root_delay};
        exp[1] = {m_root_disp, m_ref_id};
        exp[2] = {t_tx[63:32] - 32'd1, 32'h0};
        exp[3] = p_origin;
        exp[4] = t_rec;
        exp[5] = t_tx + ofs;
        tick();
        p_transmit = 1'b0;
        p_origin   = 64'h0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("blk%0d wr_en", i), {63'h0, bus.o_tx_wr_en}, 64'h1);
            chk($sformatf("blk%0d busy", i),  {63'h0, busy}, 64'h1);
            chk($sformatf("blk%0d index", i), {61'h0, bus.o_tx_ntp_header_block}, 64'(i));
            chk($sformatf("blk%0d data", i),  bus.o_tx_ntp_header_data, exp[i]);
            last_words[i] = bus.o_tx_ntp_header_data;
            if (mode == 1 && (i == 1 || i == 3)) begin
                p_transmit = 1'b1; p_record = 1'b1; p_clear = 1'b1;
            end
            tick();
            p_transmit = 1'b0; p_record = 1'b0; p_clear = 1'b0;
        end
        chk_idle_outputs("post-run");
        if (mode == 1) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("no extra words", {63'h0, bus.o_tx_wr_en}, 64'h0);
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;   // expected read data on the following cycle
    } api_vec_t;

    api_vec_t vecs [18];

    initial begin
        total = 0; bad = 0;
        vecs[0]  = '{1'b0, 8'h00, 32'h0,        32'h74696d65};
        vecs[1]  = '{1'b0, 8'h01, 32'h0,        32'h73746d70};
        vecs[2]  = '{1'b0, 8'h10, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 8'h02, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 8'h10, 32'hdeadbeef, 32'h0};
        vecs[5]  = '{1'b1, 8'h11, 32'h1007de1a, 32'h0};
        vecs[6]  = '{1'b1, 8'h12, 32'h1007d155, 32'h0};
        vecs[7]  = '{1'b1, 8'h13, 32'habad1dea, 32'h0};
        vecs[8]  = '{1'b1, 8'h14, 32'hc01df00d, 32'h0};
        vecs[9]  = '{1'b1, 8'h00, 32'h11111111, 32'h0};
        vecs[10] = '{1'b1, 8'h20, 32'h22222222, 32'h0};
        vecs[11] = '{1'b0, 8'h10, 32'h0,        32'hdeadbeef};
        vecs[12] = '{1'b0, 8'h11, 32'h0,        32'h1007de1a};
        vecs[13] = '{1'b0, 8'h12, 32'h0,        32'h1007d155};
        vecs[14] = '{1'b0, 8'h13, 32'h0,        32'habad1dea};
        vecs[15] = '{1'b0, 8'h14, 32'h0,        32'hc01df00d};
        vecs[16] = '{1'b0, 8'h00, 32'h0,        32'h74696d65};
        vecs[17] = '{1'b0, 8'h20, 32'h0,        32'h0};

        areset = 1'b0; ntp_time = 64'h0; inc_time = 1'b0;
        p_clear = 1'b0; p_record = 1'b0; p_transmit = 1'b0;
        p_origin = 64'h0; p_version = 3'd0; p_poll = 8'h0;
        bus.i_api_cs = 1'b0; bus.i_api_we = 1'b0;
        bus.i_api_address = 8'h0; bus.i_api_write_data = 32'h0;
        tick(); tick();
        chk_idle_outputs("reset");
        chk("reset read_data", {32'h0, bus.o_api_read_data}, 64'h0);
        areset = 1'b1;
        tick();
        chk("after release read_data", {32'h0, bus.o_api_read_data}, 64'h0);

        for (int v = 0; v < 18; v++) begin
            bus.i_api_cs = 1'b1; bus.i_api_we = vecs[v].we;
            bus.i_api_address = vecs[v].addr; bus.i_api_write_data = vecs[v].data;
            tick();
            bus.i_api_cs = 1'b0; bus.i_api_we = 1'b0;
            chk($sformatf("api vec%0d", v), {32'h0, bus.o_api_read_data}, {32'h0, vecs[v].exp});
            tick();
            chk($sformatf("api vec%0d idle", v), {32'h0, bus.o_api_read_data}, 64'h0);
        end

        m_config = 32'h0; m_root_delay = 32'h1007de1a;
        m_root_disp = 32'h1007d155; m_ref_id = 32'habad1dea;
        api_write(8'h10, 32'h0);
        api_write(8'h14, 32'h0);

        ntp_time = 64'hFFFFEEEE_12345678;
        inc_time = 1'b1;
        run_tx(0, 64'h0, 3'd0, 8'h00);
        chk("spec block0", last_words[0], 64'h040100001007de1a);
        chk("spec block1", last_words[1], 64'h1007d155abad1dea);
        chk("spec block2", last_words[2], 64'hffffeeed00000000);

        for (int r = 0; r < 10; r++) run_tx(0, 64'h0, 3'(r), 8'(r * 3));

        api_write(8'h14, 32'h10);
        run_tx(0, 64'h10, 3'd4, 8'h06);

        m_config = 32'h8000_0014;
        api_write(8'h10, m_config);
        run_tx(1, 64'h10, 3'd3, 8'h11);

        run_tx(2, 64'h10, 3'd4, 8'h0a);
        chk("clear+record block4", last_words[4], 64'h0);

        // Back-to-back transmit straight after the previous run.
        run_tx(0, 64'h10, 3'd4, 8'h0a);

        // Seconds rollover for the reference timestamp.
        ntp_time = 64'h00000000_fffffff0;
        run_tx(0, 64'h10, 3'd4, 8'h01);
        chk("rollover block2", last_words[2], 64'hffffffff00000000);

        // Abort mid-transmission with reset.
        p_transmit = 1'b1;
        tick();
        p_transmit = 1'b0;
        tick(); tick();
        chk("pre-abort wr_en", {63'h0, bus.o_tx_wr_en}, 64'h1);
        areset = 1'b0;
        #1;
        chk_idle_outputs("abort");
        tick();
        areset = 1'b1;
        tick();
        chk_idle_outputs("after abort");
        bus.i_api_cs = 1'b1; bus.i_api_we = 1'b0; bus.i_api_address = 8'h10;
        tick();
        bus.i_api_cs = 1'b0;
        chk("config after reset", {32'h0, bus.o_api_read_data}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
